mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences a single-ported unified instruction/data memory shared between the pipeline's IF stage and MEM stage.
- Grants one access at a time, drives the memory's req/ack handshake and registers returned read data.
- Generates the stall signals the pipeline controller uses to freeze stages while an access is outstanding.
- Sits between the datapath's fetch/memory stages and the external RAM model.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data word width in bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
if_req  input  1  instruction fetch request; held stable until if_valid
if_addr  input  ADDR_W  fetch address
if_rdata  output  DATA_W  fetched instruction, registered
if_valid  output  1  one-cycle pulse: fetch complete
mem_rd  input  1  data read request; held until mem_valid
mem_wr  input  1  data write request; held until mem_valid
mem_addr  input  ADDR_W  data address
mem_wdata  input  DATA_W  store data
mem_rdata  output  DATA_W  load data, registered
mem_valid  output  1  one-cycle pulse: data access complete
stall_if  output  1  freeze PC/IF stage
stall_all  output  1  freeze whole pipeline
ram_req  output  1  memory request, held until ram_ack
ram_we  output  1  write enable, qualified by ram_req
ram_addr  output  ADDR_W  memory address, registered
ram_wdata  output  DATA_W  memory write data, registered
ram_rdata  input  DATA_W  memory read data, valid with ram_ack
ram_ack  input  1  memory completion, one cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - ram_req, ram_we, if_valid and mem_valid = 0.
  - ram_addr, ram_wdata, if_rdata and mem_rdata = 0.
  - last_grant = DATA.
- FSM states: IDLE, DATA, INST.
- IDLE, at each edge:
  - Requests present and a completion pulse not asserted this cycle → choose a grant.
  - Data access wins over fetch, except when last_grant=DATA and if_req is pending; then INST wins. This is the anti-starvation rule: data and fetch alternate under contention.
  - On a grant, latch address, write data and ram_we (DATA: ram_we=mem_wr; INST: ram_we=0).
  - On a grant, set ram_req=1 and update last_grant.
  - mem_rd and mem_wr both high: treat as a write.
- DATA/INST: hold ram_req and all ram_* outputs stable until ram_ack.
- On ram_ack edge:
  - Drop ram_req and return to IDLE.
  - Pulse mem_valid or if_valid for exactly one cycle.
  - Load the matching rdata register from ram_rdata (reads only; mem_rdata unchanged on writes).
- Latency: request sampled at edge N → ram_req high from N+1. ack at edge M → valid high cycle M+1.
  - Minimum 2 cycles: ack in the first ram_req cycle.
- No new grant in the cycle a valid pulse is high. This prevents a held request from being re-served.
  - Back-to-back accesses are therefore spaced ≥3 cycles apart.
- Stall outputs (combinational):
  - stall_all = (mem_rd|mem_wr) & ~mem_valid.
  - stall_if = (if_req & ~if_valid) | stall_all.
- ram_ack in IDLE is ignored. This covers stale acks after reset.
- Reset mid-access aborts immediately. No valid pulse is produced for the aborted access.
- Requests deasserted while granted: the access still completes and the valid pulse is still produced; requesters must not do this.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds output perf_stall_cycles (32 bits), counting cycles with stall_all=1, saturating at 2^32-1.
  - Adds output perf_conflicts (16 bits), counting IDLE grant decisions made with both requests pending, saturating.
  - Both counters reset to 0 on rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then single fetch, if_addr=0x40, RAM acks first cycle with 0x8C410004 → ram_req high 1 cycle; if_valid pulses 2 cycles after request, if_rdata=0x8C410004; stall_if high until the pulse.
- Load and fetch simultaneous, last_grant=DATA after reset → INST granted first; then DATA granted 3 cycles after INST grant; stall_all high throughout until mem_valid.
- Store mem_addr=0x100, mem_wdata=0xDEADBEEF, ack delayed 4 cycles → ram_we=1, ram_addr=0x100, ram_wdata=0xDEADBEEF stable for all 5 req cycles; mem_valid pulses once; mem_rdata unchanged.
- Continuous load stream with if_req held → grants alternate DATA/INST; fetch is never starved more than one data access.
- rst pulled low during a DATA access with ack pending, ack arrives after release → no valid pulse; ram_req=0; FSM in IDLE; stale ack ignored.
- With MEM_ARB_PERF_CNT_EN, 3 contended loads of 2-cycle latency → perf_conflicts=3; perf_stall_cycles equals the observed stall_all count.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter for a single-ported unified instruction/data memory shared by IF and MEM stages.
// Optional performance counters are compiled in when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              stall_if,
  output logic              stall_all,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [15:0]       perf_conflicts
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] INST = 2'd2;

  logic [1:0] state;
  logic       last_data;
  logic       data_pend;
  logic       pulse;
  logic       can_grant;
  logic       pick_inst;

  assign data_pend = mem_rd | mem_wr;
  assign pulse     = if_valid | mem_valid;
  // A valid pulse still being high means the requester has not yet seen completion,
  // so granting now would re-serve the same held request.
  assign can_grant = (state == IDLE) && !pulse && (data_pend || if_req);
  assign pick_inst = if_req && (!data_pend || last_data);

  assign stall_all = data_pend & ~mem_valid;
  assign stall_if  = (if_req & ~if_valid) | stall_all;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_data <= 1'b1;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the pulses default low and are
      // overridden below, which is safe because the last NBA in the block wins.
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (can_grant) begin
            ram_req   <= 1'b1;
            last_data <= !pick_inst;
            if (pick_inst) begin
              state    <= INST;
              ram_addr <= if_addr;
              ram_we   <= 1'b0;
            end else begin
              state     <= DATA;
              ram_addr  <= mem_addr;
              ram_wdata <= mem_wdata;
              ram_we    <= mem_wr;
            end
          end
        end
        DATA, INST: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            state   <= IDLE;
            if (state == INST) begin
              if_valid <= 1'b1;
              if_rdata <= ram_rdata;
            end else begin
              mem_valid <= 1'b1;
              if (!ram_we) mem_rdata <= ram_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_conflicts    <= '0;
    end else begin
      if (stall_all && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (can_grant && data_pend && if_req && perf_conflicts != 16'hFFFF)
        perf_conflicts <= perf_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small responding RAM model.
// Define MEM_ARB_PERF_CNT_EN to also exercise the performance counters.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        stall_if;
  logic        stall_all;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ack = 1'b0;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_conflicts;
`endif

  int checks = 0;
  int failures = 0;

  // RAM model: acks during the ack_lat-th cycle that ram_req is high.
  logic        model_en = 1'b1;
  int          ack_lat = 1;
  int          req_cnt = 0;
  logic [31:0] rdata_val = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .stall_if(stall_if), .stall_all(stall_all),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (model_en) begin
      if (ram_req) begin
        req_cnt   = req_cnt + 1;
        ram_ack   = (req_cnt == ack_lat);
        ram_rdata = rdata_val;
      end else begin
        req_cnt = 0;
        ram_ack = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  int grants;
  int sc;
  logic prev_req;

  initial begin
    do_reset();
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_valids", {if_valid, mem_valid}, 0);
    check("rst_rdata", {if_rdata, mem_rdata}, 0);
    check("rst_stalls", {stall_if, stall_all}, 0);

    // Single fetch, ack in first request cycle.
    ack_lat = 1; rdata_val = 32'h8C41_0004;
    if_addr = 32'h40; if_req = 1'b1;
    #1 check("f_stall_if_pre", stall_if, 1);
    step();
    check("f_req", ram_req, 1);
    check("f_addr", ram_addr, 32'h40);
    check("f_we", ram_we, 0);
    check("f_stall_if", stall_if, 1);
    step();
    check("f_valid", if_valid, 1);
    check("f_rdata", if_rdata, 32'h8C41_0004);
    check("f_req_drop", ram_req, 0);
    check("f_stall_if_done", stall_if, 0);
    if_req = 1'b0;
    step();
    check("f_valid_once", if_valid, 0);

    // Simultaneous load + fetch after reset: INST first, DATA 3 cycles later.
    do_reset();
    rdata_val = 32'h1111_2222;
    if_addr = 32'h44; if_req = 1'b1;
    mem_addr = 32'h200; mem_rd = 1'b1;
    step();
    check("c_inst_first", ram_addr, 32'h44);
    check("c_req1", ram_req, 1);
    check("c_stall_all1", stall_all, 1);
    step();
    check("c_if_valid", if_valid, 1);
    check("c_if_rdata", if_rdata, 32'h1111_2222);
    check("c_stall_all2", stall_all, 1);
    if_req = 1'b0;
    rdata_val = 32'h3333_4444;
    step();
    check("c_no_regrant", ram_req, 0);
    check("c_stall_all3", stall_all, 1);
    step();
    check("c_data_req", ram_req, 1);
    check("c_data_addr", ram_addr, 32'h200);
    step();
    check("c_mem_valid", mem_valid, 1);
    check("c_mem_rdata", mem_rdata, 32'h3333_4444);
    check("c_stall_all_done", stall_all, 0);
    mem_rd = 1'b0;
    step();
    check("c_mem_valid_once", mem_valid, 0);

    // Store with delayed ack: 5 request cycles with stable outputs.
    ack_lat = 5; rdata_val = 32'h5555_5555;
    mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF; mem_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("s_hold%0d", i), {ram_req, ram_we, ram_addr, ram_wdata},
            {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF});
      check($sformatf("s_novalid%0d", i), mem_valid, 0);
    end
    step();
    check("s_mem_valid", mem_valid, 1);
    check("s_rdata_kept", mem_rdata, 32'h3333_4444);
    check("s_req_drop", ram_req, 0);
    mem_wr = 1'b0;
    step();
    check("s_valid_once", mem_valid, 0);

    // Continuous contention: grants alternate, INST first since last grant was DATA.
    ack_lat = 1;
    if_addr = 32'h80; if_req = 1'b1;
    mem_addr = 32'h300; mem_rd = 1'b1;
    grants = 0; prev_req = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (ram_req && !prev_req) begin
        check($sformatf("alt_grant%0d", grants), ram_addr,
              (grants % 2 == 0) ? 32'h80 : 32'h300);
        grants++;
      end
      prev_req = ram_req;
    end
    check("alt_count", grants, 6);
    if_req = 1'b0; mem_rd = 1'b0;
    step();
    step();

    // Reset mid-access, stale ack afterwards must be ignored.
    model_en = 1'b0;
    ram_ack = 1'b0;
    mem_addr = 32'h400; mem_rd = 1'b1;
    step();
    check("r_req_before", ram_req, 1);
    rst = 1'b0;
    #1;
    check("r_req_abort", ram_req, 0);
    mem_rd = 1'b0;
    step();
    rst = 1'b1;
    step();
    ram_ack = 1'b1; ram_rdata = 32'h7777_7777;
    step();
    ram_ack = 1'b0;
    check("r_no_valid", {mem_valid, if_valid}, 0);
    check("r_req_idle", ram_req, 0);
    check("r_rdata_clear", mem_rdata, 0);
    step();
    check("r_no_valid2", {mem_valid, if_valid, ram_req}, 0);
    model_en = 1'b1;
    step();

`ifdef MEM_ARB_PERF_CNT_EN
    // Three contended grants with 2-cycle latency.
    do_reset();
    check("p_rst", {perf_stall_cycles, perf_conflicts}, 0);
    ack_lat = 1;
    if_addr = 32'h80; if_req = 1'b1;
    mem_addr = 32'h300; mem_rd = 1'b1;
    sc = 0;
    for (int i = 0; i < 8; i++) begin
      if (stall_all) sc++;
      step();
    end
    if_req = 1'b0; mem_rd = 1'b0;
    step();
    step();
    check("p_conflicts", perf_conflicts, 3);
    check("p_stall_cycles", perf_stall_cycles, sc);
    check("p_stall_hand", sc, 7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
